aurora_tx_lane: RTL and testbench

Transmit lane for the Aurora 64b/66b link, the counterpart of the receive lane. It accepts 66-bit blocks (2-bit sync header plus 64-bit payload) over a valid/ready handshake. It scrambles the payload with the self-synchronous x^58+x^39+1 scrambler, inserts idle blocks when starved, and gearboxes the 66-bit stream into one 32-bit word per clock for an external 32:1 serializer. One block enters per 66 bits of line time: 16 blocks per 33 clocks.

---
 rtl/aurora_pkg.sv | 39 +++
 rtl/aurora_tx_gearbox.sv | 55 +++++
 rtl/aurora_tx_lane.sv | 69 ++++++
 tb/tb_aurora_tx_lane.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/aurora_pkg.sv
// Shared constants, types and the block scrambler for the Aurora 64b/66b lanes.
package aurora_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;
  localparam logic [7:0] BT_IDLE  = 8'h78;

  localparam int unsigned SCR_TAP_A = 38;
  localparam int unsigned SCR_TAP_B = 57;
  typedef logic [57:0] scr_state_t;
  localparam scr_state_t  SCR_SEED  = 58'h3FF_FFFF_FFFF_FFFF;
  localparam logic [63:0] IDLE_DATA = {BT_IDLE, 56'h0};

  localparam int unsigned BLOCK_W = 66;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned SEQ_LEN = 33;
  localparam int unsigned BUF_W   = 96;

  typedef struct packed {
    scr_state_t  state;
    logic [63:0] data;
  } scr_result_t;

  // Scrambles a full payload in transmit order (bit 63 first) from state s_in.
  function automatic scr_result_t scramble(input scr_state_t s_in, input logic [63:0] d);
    scr_state_t  s;
    logic [63:0] o;
    logic        b;
    s = s_in;
    o = '0;
    for (int i = 63; i >= 0; i--) begin
      b    = d[i] ^ s[SCR_TAP_A] ^ s[SCR_TAP_B];
      o[i] = b;
      s    = {s[56:0], b};
    end
    return '{state: s, data: o};
  endfunction

endpackage

// File: rtl/aurora_tx_gearbox.sv
// 66:32 gearbox: MSB-aligned bit buffer, occupancy count and phase counter.
module aurora_tx_gearbox
  import aurora_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [BLOCK_W-1:0] block_i,
  output logic               ready_o,
  output logic [WORD_W-1:0]  word_o,
  output logic [5:0]         seq_o
);

  localparam logic [6:0] WordCnt  = 7'(WORD_W);
  localparam logic [6:0] LoadStep = 7'(BLOCK_W - WORD_W);
  localparam logic [5:0] SeqLast  = 6'(SEQ_LEN - 1);

  // Valid bits sit at the top of r_buf (oldest at bit 95); everything below is zero.
  logic [BUF_W-1:0] r_buf;
  logic [6:0]       r_cnt;
  logic [5:0]       r_seq;

  logic [BUF_W-1:0] w_load;
  logic [BUF_W-1:0] w_merged;
  logic [6:0]       w_cnt_next;

  assign ready_o = (r_cnt < WordCnt);

  // Place the new block behind the residual bits, then account for one emitted word.
  always_comb begin
    w_load     = '0;
    w_cnt_next = r_cnt - WordCnt;
    if (ready_o) begin
      w_load     = {block_i, {(BUF_W - BLOCK_W){1'b0}}} >> r_cnt;
      w_cnt_next = r_cnt + LoadStep;
    end
    w_merged = r_buf | w_load;
  end

  assign word_o = w_merged[BUF_W-1 -: WORD_W];
  assign seq_o  = r_seq;

  // Buffer, occupancy and phase registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_buf <= '0;
      r_cnt <= '0;
      r_seq <= '0;
    end else begin
      r_buf <= w_merged << WORD_W;
      r_cnt <= w_cnt_next;
      r_seq <= (r_seq == SeqLast) ? 6'd0 : r_seq + 6'd1;
    end
  end

endmodule

// File: rtl/aurora_tx_lane.sv
// Aurora 64b/66b transmit lane: idle insertion, scrambler, gearbox and output register.
module aurora_tx_lane
  import aurora_pkg::*;
(
  input  logic        clk_tx_i,
  input  logic        rst_n_i,
  input  logic [63:0] tx_data_i,
  input  logic [1:0]  tx_header_i,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic        tx_polarity_i,
  output logic [31:0] tx_data_o,
  output logic        tx_idle_o,
  output logic [5:0]  tx_seq_o
);

  scr_state_t  r_scr;
  logic [31:0] r_data;
  logic        r_idle;

  logic               w_ready;
  logic [1:0]         w_header;
  logic [63:0]        w_payload;
  scr_result_t        w_scr;
  logic [BLOCK_W-1:0] w_block;
  logic [WORD_W-1:0]  w_word;

  // Substitute an idle block whenever the source has nothing to offer.
  always_comb begin
    w_header  = HDR_CTRL;
    w_payload = IDLE_DATA;
    if (tx_valid_i) begin
      w_header  = tx_header_i;
      w_payload = tx_data_i;
    end
  end

  assign w_scr   = scramble(r_scr, w_payload);
  assign w_block = {w_header, w_scr.data};

  aurora_tx_gearbox u_gearbox (
    .clk_i   (clk_tx_i),
    .rst_ni  (rst_n_i),
    .block_i (w_block),
    .ready_o (w_ready),
    .word_o  (w_word),
    .seq_o   (tx_seq_o)
  );

  // Output word with polarity, idle flag, and scrambler state advancing only on loads.
  always_ff @(posedge clk_tx_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_data <= '0;
      r_idle <= 1'b0;
      r_scr  <= SCR_SEED;
    end else begin
      r_data <= w_word ^ {WORD_W{tx_polarity_i}};
      r_idle <= w_ready & ~tx_valid_i;
      if (w_ready) begin
        r_scr <= w_scr.state;
      end
    end
  end

  assign tx_ready_o = w_ready;
  assign tx_data_o  = r_data;
  assign tx_idle_o  = r_idle;

endmodule

// File: tb/tb_aurora_tx_lane.sv
// Self-checking bench for aurora_tx_lane: vector table, bit-serial line model and a descrambling receiver.
module tb_aurora_tx_lane;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] din = '0;
  logic [1:0]  hin = 2'b01;
  logic        vin = 1'b0;
  logic        pol = 1'b0;
  logic        ready;
  logic [31:0] dout;
  logic        idle;
  logic [5:0]  seq;

  int checks = 0;
  int failures = 0;

  localparam logic [57:0] SEED = {58{1'b1}};
  localparam logic [63:0] IDLE_PAY = 64'h7800_0000_0000_0000;

  // line model
  bit          mq[$];
  logic [57:0] ms;
  int          mseq;
  bit          acc;
  // receiver
  bit          rx_on;
  bit          rq[$];
  logic [57:0] rs;
  bit          rx_have;
  logic [63:0] rx_last;
  int          rx_blocks;
  int          rx_idles;

  aurora_tx_lane dut (
    .clk_tx_i      (clk),
    .rst_n_i       (rst_n),
    .tx_data_i     (din),
    .tx_header_i   (hin),
    .tx_valid_i    (vin),
    .tx_ready_o    (ready),
    .tx_polarity_i (pol),
    .tx_data_o     (dout),
    .tx_idle_o     (idle),
    .tx_seq_o      (seq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic rx_feed(input logic [31:0] w);
    logic [65:0] b;
    logic [63:0] d;
    bit          s;
    for (int i = 31; i >= 0; i--) rq.push_back(w[i]);
    while (rq.size() >= 66) begin
      for (int i = 65; i >= 0; i--) b[i] = rq.pop_front();
      for (int i = 63; i >= 0; i--) begin
        s    = b[i];
        d[i] = s ^ rs[38] ^ rs[57];
        rs   = {rs[56:0], s};
      end
      if (b[65:64] == 2'b10 && d == IDLE_PAY) begin
        rx_idles++;
      end else begin
        check("rx_hdr", {62'd0, b[65:64]}, 64'd1);
        if (rx_have) check("rx_cnt", d, {rx_last[31:0] + 32'd1, rx_last[31:0] + 32'd1});
        rx_last = d;
        rx_have = 1'b1;
        rx_blocks++;
      end
    end
  endtask

  // One clock: predict from the bit-serial model, clock, then compare.
  task automatic cycle();
    bit          load;
    logic [65:0] blk;
    logic [31:0] ew;
    bit          s;
    load = (mq.size() < 32);
    if (load) begin
      blk = vin ? {hin, din} : {2'b10, IDLE_PAY};
      mq.push_back(blk[65]);
      mq.push_back(blk[64]);
      for (int i = 63; i >= 0; i--) begin
        s  = blk[i] ^ ms[38] ^ ms[57];
        ms = {ms[56:0], s};
        mq.push_back(s);
      end
    end
    for (int i = 31; i >= 0; i--) ew[i] = mq.pop_front() ^ pol;
    mseq = (mseq == 32) ? 0 : mseq + 1;
    acc  = load && vin;
    @(posedge clk);
    #1;
    check("word", {32'd0, dout}, {32'd0, ew});
    check("idle", {63'd0, idle}, {63'd0, (load && !vin)});
    check("ready", {63'd0, ready}, {63'd0, (mq.size() < 32)});
    check("seq", {58'd0, seq}, 64'(mseq));
    if (rx_on) rx_feed(dout ^ {32{pol}});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_word", {32'd0, dout}, 64'd0);
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_idle", {63'd0, idle}, 64'd0);
    check("rst_seq", {58'd0, seq}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mq.delete();
    ms = SEED;
    mseq = 0;
    rq.delete();
    rs = SEED;
    rx_have = 1'b0;
    #1;
    check("rel_seq", {58'd0, seq}, 64'd0);
  endtask

  // Stream {cnt,cnt} data blocks, advancing only on accepted handshakes.
  logic [31:0] cnt;
  task automatic stream(input int n);
    for (int i = 0; i < n; i++) begin
      cycle();
      if (acc) begin
        cnt = cnt + 32'd1;
        din = {cnt, cnt};
      end
    end
  endtask

  typedef struct {
    logic        v;
    logic [63:0] d;
    logic        p;
    logic        e_rdy;
    logic        e_idle;
    logic [5:0]  e_seq;
    logic [31:0] e_word;
    logic [31:0] e_mask;
  } vec_t;
  vec_t vecs[5];

  int idle_cnt;
  int rdy_low;
  int wraps;
  int idles_before;
  int guard;

  initial begin
    vecs[0] = '{1'b1, 64'h0, 1'b0, 1'b0, 1'b0, 6'd1, 32'h4000_0000, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 6'd2, 32'h007F_FFF0, 32'hFFFF_FFFF};
    vecs[2] = '{1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 6'd3, 32'h2000_0000, 32'hF000_0000};
    vecs[3] = '{1'b1, 64'h0, 1'b0, 1'b1, 1'b0, 6'd4, 32'h0000_0000, 32'h0000_0000};
    vecs[4] = '{1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 6'd5, 32'h0400_0000, 32'h0C00_0000};
    rx_on = 1'b0;
    rx_blocks = 0;
    rx_idles = 0;
    cnt = '0;

    // first blocks after reset against hand-computed words
    do_reset();
    hin = 2'b01;
    for (int i = 0; i < 5; i++) begin
      vin = vecs[i].v;
      din = vecs[i].d;
      pol = vecs[i].p;
      cycle();
      check("tbl_word", {32'd0, dout & vecs[i].e_mask}, {32'd0, vecs[i].e_word & vecs[i].e_mask});
      check("tbl_ready", {63'd0, ready}, {63'd0, vecs[i].e_rdy});
      check("tbl_idle", {63'd0, idle}, {63'd0, vecs[i].e_idle});
      check("tbl_seq", {58'd0, seq}, {58'd0, vecs[i].e_seq});
    end
    pol = 1'b0;

    // starved line: two full periods of idles
    do_reset();
    vin = 1'b0;
    for (int p = 0; p < 2; p++) begin
      idle_cnt = 0;
      rdy_low = 0;
      wraps = 0;
      for (int c = 0; c < 33; c++) begin
        cycle();
        if (idle) idle_cnt++;
        if (!ready) rdy_low++;
        if (seq == 6'd0) wraps++;
      end
      check("per_idles", 64'(idle_cnt), 64'd16);
      check("per_rdy_low", 64'(rdy_low), 64'd17);
      check("per_wraps", 64'(wraps), 64'd1);
      check("per_end_seq", {58'd0, seq}, 64'd0);
    end

    // polarity inverted first words
    do_reset();
    pol = 1'b1;
    vin = 1'b1;
    din = '0;
    cycle();
    check("pol_w0", {32'd0, dout}, 64'hBFFF_FFFF);
    cycle();
    check("pol_w1", {32'd0, dout}, 64'hFF80_000F);
    pol = 1'b0;

    // continuous counting stream through the receiver, inverted then normal polarity
    do_reset();
    rx_on = 1'b1;
    cnt = '0;
    din = {cnt, cnt};
    vin = 1'b1;
    pol = 1'b1;
    stream(40);
    pol = 1'b0;
    stream(40);
    check("rx_progress", 64'(rx_blocks >= 35), 64'd1);
    check("rx_no_idle", 64'(rx_idles), 64'd0);

    // a single starved ready cycle inserts exactly one idle
    idles_before = rx_idles;
    guard = 0;
    while (mq.size() >= 32 && guard < 4) begin
      stream(1);
      guard++;
    end
    vin = 1'b0;
    cycle();
    check("one_idle_pulse", {63'd0, idle}, 64'd1);
    vin = 1'b1;
    stream(40);
    check("one_idle_rx", 64'(rx_idles - idles_before), 64'd1);

    // reset at phase 17, then relock and resume
    guard = 0;
    while (seq != 6'd17 && guard < 40) begin
      stream(1);
      guard++;
    end
    check("reach_ph17", {58'd0, seq}, 64'd17);
    do_reset();
    stream(80);
    check("relock", 64'(rx_have), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
